// File: rtl/fetch_pkg.sv
// Shared encodings and constants for the fetch-stage control unit.
package fetch_pkg;

    // PC source select, one-hot {JR, J, B}; all-zero selects PC+4.
    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_B   = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b100;

    // Trap FSM state.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_RUN       = 1'b0;
    localparam fetch_state_t ST_TRAP_WAIT = 1'b1;

    // Kernel-space vectors; bit 31 marks kernel code.
    localparam logic [31:0] VEC_KERNEL_BASE = 32'h8000_0000;
    localparam logic [31:0] VEC_EXCEPTION   = 32'h8000_0004;
    localparam logic [31:0] VEC_INTERRUPT   = 32'h8000_0008;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level input.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; the last flop is the safe copy.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage pipeline control: redirect arbitration, load-use stall,
// pending-interrupt latch and a trap FSM that blocks trap re-entry.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             irq_in,
    input  logic             ld_use,
    input  logic             br_taken,
    input  logic             j_id,
    input  logic             jr_id,
    input  logic             exc_id,
    input  logic             id_kernel,
    output logic [2:0]       PCSrc,
    output logic             IF_Pause,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EX_Flush,
    output logic             intruption,
    output logic             exception,
    output logic             irq_ack,
    output logic [CNT_W-1:0] trap_cnt
);

    fetch_state_t     state_q, state_d;
    logic             irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    logic             irq_s;
    logic             in_run;
    logic             take_exc;
    logic             take_irq;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       (irq_in),
        .q       (irq_s)
    );

    assign in_run = (state_q == ST_RUN);

    // A taken branch means the ID instruction is wrong-path, so it cannot trap.
    assign take_exc = !br_taken && in_run && exc_id;
    // Interrupts are only taken while ID holds user code.
    assign take_irq = !br_taken && in_run && !exc_id && irq_pend_q && !id_kernel;

    // Priority arbitration of redirects, traps and the load-use stall.
    always_comb begin
        PCSrc      = PCSRC_SEQ;
        IF_Pause   = 1'b0;
        IF_Flush   = 1'b0;
        ID_Flush   = 1'b0;
        EX_Flush   = 1'b0;
        intruption = 1'b0;
        exception  = 1'b0;
        irq_ack    = 1'b0;
        if (br_taken) begin
            PCSrc    = PCSRC_B;
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
        end else if (take_exc) begin
            exception = 1'b1;
            IF_Flush  = 1'b1;
            ID_Flush  = 1'b1;
            // The stalled load's dependent bubble must not survive the trap.
            EX_Flush  = ld_use;
        end else if (take_irq) begin
            intruption = 1'b1;
            irq_ack    = 1'b1;
            IF_Flush   = 1'b1;
            ID_Flush   = 1'b1;
        end else if (ld_use) begin
            // Jumps in ID are held off and re-present after the stall.
            IF_Pause = 1'b1;
            ID_Flush = 1'b1;
        end else if (jr_id) begin
            // JR wins over J if the decoder ever raises both.
            PCSrc    = PCSRC_JR;
            IF_Flush = 1'b1;
        end else if (j_id) begin
            PCSrc    = PCSRC_J;
            IF_Flush = 1'b1;
        end
    end

    // Next-state for trap FSM, pending latch and trap counter.
    always_comb begin
        state_d    = state_q;
        irq_pend_d = irq_pend_q | irq_s;
        trap_cnt_d = trap_cnt_q;
        if (take_exc || take_irq) begin
            state_d    = ST_TRAP_WAIT;
            trap_cnt_d = trap_cnt_q + CNT_W'(1);
        end else if (!in_run && id_kernel) begin
            state_d = ST_RUN;
        end
        // Clearing wins on the take edge; a held irq re-latches one cycle later.
        if (take_irq) begin
            irq_pend_d = 1'b0;
        end
    end

    // Control-state registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_RUN;
            irq_pend_q <= 1'b0;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign trap_cnt = trap_cnt_q;

    // Structural invariants of the arbitration.
    always_comb begin
        assert (!(IF_Pause && (PCSrc != PCSRC_SEQ || intruption || exception)));
        assert (!((intruption || exception) && PCSrc != PCSRC_SEQ));
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Pipeline control unit for the fetch stage.
- Arbitrates every PC-redirect source: EX branch, ID jump/jr, external interrupt, ID exception.
- Arbitrates the load-use stall and drives the fetch stage's PCSrc, IF_Pause, IF_Flush, intruption and exception inputs, plus ID/EX flushes.
- Holds the synchronised pending-interrupt latch and a trap FSM that masks re-entry until the kernel handler reaches ID.

Parameters:
- SYNC_STAGES, 2, flops in the irq_in synchroniser (min 2).
- CNT_W, 16, width of the taken-trap counter.

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous, active-low reset
- irq_in  in  1  level interrupt from peripherals, asynchronous to clk
- ld_use  in  1  load-use hazard from hazard detector (ID needs EX load result)
- br_taken  in  1  branch in EX resolved taken
- j_id  in  1  J/JAL decoded in ID
- jr_id  in  1  JR/JALR decoded in ID
- exc_id  in  1  undefined/illegal instruction in ID
- id_kernel  in  1  bit 31 of the PC of the instruction in ID (1 = kernel)
- PCSrc  out  3  {JR,J,B} one-hot or 000
- IF_Pause  out  1  freeze PC and IF_ID
- IF_Flush  out  1  load bubble into IF_ID
- ID_Flush  out  1  bubble ID/EX
- EX_Flush  out  1  bubble EX/MEM
- intruption  out  1  redirect to interrupt vector
- exception  out  1  redirect to exception vector
- irq_ack  out  1  one-cycle pulse when interrupt taken
- trap_cnt  out  CNT_W  count of taken interrupts+exceptions, wraps

Behaviour:
- Reset: all outputs 0, PCSrc=000, state=RUN, irq_pend=0, synchroniser cleared, trap_cnt=0.
- Control outputs are combinational from inputs + registered state, so the fetch stage samples them on the same edge.
- irq_s is irq_in after SYNC_STAGES flops. irq_pend sets on irq_s=1. It clears only on the edge where the interrupt is taken. It re-sets next cycle if irq_s is still high.
- FSM states: RUN, TRAP_WAIT.
  - In TRAP_WAIT, irq and exc_id are ignored.
  - Branch, jump and stall handling stay active in TRAP_WAIT.
  - TRAP_WAIT goes to RUN on the first cycle id_kernel=1.
- Priority per cycle, first match wins:
  1. br_taken: PCSrc=001, IF_Flush=1, ID_Flush=1. Other ID-side requests are suppressed; they are wrong-path. ld_use ignored.
  2. exc_id (RUN only): exception=1, IF_Flush=1, ID_Flush=1, trap_cnt+1, state goes to TRAP_WAIT.
  3. irq_pend & ~id_kernel (RUN only): intruption=1, irq_ack=1, IF_Flush=1, ID_Flush=1, irq_pend cleared, trap_cnt+1, state goes to TRAP_WAIT. Interrupted ID instruction is discarded and re-executed from the handler's saved PC+4-4.
  4. ld_use: IF_Pause=1, ID_Flush=1. PCSrc=000. jr_id/j_id are held off; they re-present next cycle.
  5. jr_id: PCSrc=100, IF_Flush=1.
  6. j_id: PCSrc=010, IF_Flush=1.
  7. Otherwise PCSrc=000, all flushes 0.
- jr_id & j_id both high is a decoder error: PCSrc=100 wins.
- EX_Flush=1 only when exc_id fires while ld_use is also high. This kills the paired load's dependent bubble. Otherwise EX_Flush=0.
- IF_Pause is never asserted together with a redirect.
- PCSrc is never non-zero while intruption/exception=1.
- trap_cnt wraps modulo 2^CNT_W.
- Reset mid-trap returns to RUN with irq_pend=0. An interrupt still asserted is re-latched after SYNC_STAGES+1 cycles.

Decomposition:
- Package fetch_pkg holds:
  - PCSrc encodings PCSRC_SEQ=000, PCSRC_B=001, PCSRC_J=010, PCSRC_JR=100.
  - FSM state typedef {RUN, TRAP_WAIT}.
  - Vector constants 0x80000000, 0x80000004, 0x80000008, for bench use.
- One sub-module: sync_ff (SYNC_STAGES-deep synchroniser, async reset).

Test Plan:
- Reset then idle: all outputs 0, PCSrc=000, trap_cnt=0; reset_b low mid-TRAP_WAIT -> state RUN, irq_pend=0 next cycle.
- ld_use=1 with j_id=1 for 1 cycle -> IF_Pause=1, ID_Flush=1, PCSrc=000; next cycle ld_use=0, j_id=1 -> PCSrc=010, IF_Flush=1.
- br_taken=1 with exc_id=1 and jr_id=1 -> PCSrc=001, IF_Flush=ID_Flush=1, exception=0, trap_cnt unchanged.
- irq_in rises, id_kernel=0 -> intruption=1 and irq_ack=1 exactly SYNC_STAGES+1 edges later, trap_cnt=1. A second irq while in TRAP_WAIT is held pending until id_kernel=1, then taken once id_kernel returns to 0.
- irq_pend=1 with id_kernel=1 for 5 cycles -> no intruption; id_kernel falls -> intruption same cycle.
- exc_id=1 & ld_use=1 -> exception=1, EX_Flush=1, IF_Pause=0. trap_cnt preset to 0xFFFF, then one more trap -> 0x0000.
